// File: rtl/write_back_unit_if.sv
// Bundle between execute/memory/read stages and the write-back unit.
// The master side is the surrounding pipeline and the slave side is the write-back unit.
interface write_back_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GPR_WIDTH  = 3
);
  logic                  exec_valid;
  logic [GPR_WIDTH-1:0]  exec_dest;
  logic [DATA_WIDTH-1:0] exec_result;
  logic                  load_issue;
  logic [GPR_WIDTH-1:0]  load_dest;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [GPR_WIDTH-1:0]  read_address0;
  logic [GPR_WIDTH-1:0]  read_address1;
  logic                  ready;
  logic                  stall;
  logic                  write_enable;
  logic [GPR_WIDTH-1:0]  write_address;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output exec_valid, exec_dest, exec_result,
    output load_issue, load_dest,
    output mem_valid, mem_data,
    output read_address0, read_address1,
    input  ready, stall,
    input  write_enable, write_address, write_data
  );

  modport slave (
    input  exec_valid, exec_dest, exec_result,
    input  load_issue, load_dest,
    input  mem_valid, mem_data,
    input  read_address0, read_address1,
    output ready, stall,
    output write_enable, write_address, write_data
  );
endinterface

// File: rtl/write_back_unit.sv
// In-order write-back stage: a small completion queue that takes ALU results and
// load placeholders in program order, fills load data as memory returns it in
// issue order, and retires one completed head entry per cycle to the register file.
module write_back_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int GPR_WIDTH  = 3,
  parameter int DEPTH      = 4
) (
  input  logic              clock,
  input  logic              reset,
  write_back_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  // Queue storage
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      dv_q, dv_d;
  logic [GPR_WIDTH-1:0]  dest_q [DEPTH];
  logic [GPR_WIDTH-1:0]  dest_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  cnt_t                  count_q, count_d;

  // Register-file write port
  logic                  we_q, we_d;
  logic [GPR_WIDTH-1:0]  wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;

  // Control
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fill_hit_s;
  ptr_t                  fill_idx_s;
  ptr_t                  scan_idx_s;
  logic                  fill_s;
  logic                  stall_s;

  // Space check and handshake decode; ready looks only at the registered count,
  // so a retire in the same cycle never makes room for a push.
  always_comb begin
    ready_s = (count_q < cnt_t'(DEPTH));
    push_s  = ready_s & (bus.exec_valid | bus.load_issue);
    pop_s   = valid_q[head_q] & dv_q[head_q];
  end

  // Find the oldest entry still waiting for load data, scanning from the head.
  always_comb begin
    fill_hit_s = 1'b0;
    fill_idx_s = {PTR_W{1'b0}};
    scan_idx_s = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_q + ptr_t'(i);
      if (!fill_hit_s && valid_q[scan_idx_s] && !dv_q[scan_idx_s]) begin
        fill_hit_s = 1'b1;
        fill_idx_s = scan_idx_s;
      end else begin
        fill_hit_s = fill_hit_s;
      end
    end
    fill_s = bus.mem_valid & fill_hit_s;
  end

  // Next-state for queue entries, pointers, count and the write port.
  always_comb begin
    valid_d = valid_q;
    dv_d    = dv_q;
    dest_d  = dest_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + cnt_t'(push_s) - cnt_t'(pop_s);
    we_d    = pop_s;
    wa_d    = wa_q;
    wd_d    = wd_q;

    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ptr_t'(1);
      wa_d            = dest_q[head_q];
      wd_d            = data_q[head_q];
    end else begin
      head_d = head_q;
    end

    // Fill and pop never target the same slot: pop needs data present, fill needs it absent.
    if (fill_s) begin
      data_d[fill_idx_s] = bus.mem_data;
      dv_d[fill_idx_s]   = 1'b1;
    end else begin
      dv_d = dv_d;
    end

    // An ALU result takes priority over a simultaneous load issue.
    if (push_s) begin
      valid_d[tail_q] = 1'b1;
      dv_d[tail_q]    = bus.exec_valid;
      dest_d[tail_q]  = bus.exec_valid ? bus.exec_dest : bus.load_dest;
      data_d[tail_q]  = bus.exec_valid ? bus.exec_result : {DATA_WIDTH{1'b0}};
      tail_d          = tail_q + ptr_t'(1);
    end else begin
      tail_d = tail_q;
    end
  end

  // State registers; reset discards every pending entry and outstanding load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= {DEPTH{1'b0}};
      dv_q    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= {GPR_WIDTH{1'b0}};
        data_q[i] <= {DATA_WIDTH{1'b0}};
      end
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {(PTR_W+1){1'b0}};
      we_q    <= 1'b0;
      wa_q    <= {GPR_WIDTH{1'b0}};
      wd_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      dv_q    <= dv_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  // Hazard: a source matches any unretired destination or the write in flight this cycle.
  always_comb begin
    stall_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ((dest_q[i] == bus.read_address0) || (dest_q[i] == bus.read_address1))) begin
        stall_s = 1'b1;
      end else begin
        stall_s = stall_s;
      end
    end
    if (we_q && ((wa_q == bus.read_address0) || (wa_q == bus.read_address1))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = stall_s;
    end
  end

  assign bus.ready         = ready_s;
  assign bus.stall         = stall_s;
  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit: expected writes are queued in program
// order as stimulus is driven, load data is attached when memory returns it,
// and a monitor pops and compares every register-file write.
module tb_write_back_unit;
  localparam int DW = 32;
  localparam int GW = 3;

  typedef struct {
    logic [GW-1:0] addr;
    logic [DW-1:0] data;
    bit            filled;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  write_back_unit_if #(.DATA_WIDTH(DW), .GPR_WIDTH(GW)) bus();

  write_back_unit #(.DATA_WIDTH(DW), .GPR_WIDTH(GW), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Monitor: every write must match the oldest expected entry, with its data known.
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.write_enable === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.write_address, bus.write_data);
      end else begin
        mon_e = sb.pop_front();
        if (!mon_e.filled || bus.write_address !== mon_e.addr || bus.write_data !== mon_e.data) begin
          fails++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h filled=%0d",
                   bus.write_address, bus.write_data, mon_e.addr, mon_e.data, mon_e.filled);
        end
      end
    end
  end

  task automatic idle();
    bus.exec_valid  = 1'b0;
    bus.exec_dest   = 3'd0;
    bus.exec_result = 32'd0;
    bus.load_issue  = 1'b0;
    bus.load_dest   = 3'd0;
    bus.mem_valid   = 1'b0;
    bus.mem_data    = 32'd0;
  endtask

  task automatic drive_exec(input logic [GW-1:0] d, input logic [DW-1:0] r, input bit expect_accept);
    bus.exec_valid  = 1'b1;
    bus.exec_dest   = d;
    bus.exec_result = r;
    if (expect_accept) sb.push_back('{addr: d, data: r, filled: 1'b1});
  endtask

  task automatic drive_load(input logic [GW-1:0] d);
    bus.load_issue = 1'b1;
    bus.load_dest  = d;
    sb.push_back('{addr: d, data: 32'd0, filled: 1'b0});
  endtask

  task automatic drive_mem(input logic [DW-1:0] m, input bit expect_fill);
    bus.mem_valid = 1'b1;
    bus.mem_data  = m;
    if (expect_fill) begin
      for (int i = 0; i < sb.size(); i++) begin
        if (!sb[i].filled) begin
          sb[i].data   = m;
          sb[i].filled = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic chk_we(input string name, input logic exp_we);
    tests++;
    if (bus.write_enable !== exp_we) begin
      fails++;
      $display("FAIL %s: write_enable got %b required %b", name, bus.write_enable, exp_we);
    end
  endtask

  task automatic chk_ready_stall(input string name, input logic exp_ready, input logic exp_stall);
    tests++;
    if (bus.ready !== exp_ready || bus.stall !== exp_stall) begin
      fails++;
      $display("FAIL %s: ready/stall got %b/%b required %b/%b", name, bus.ready, bus.stall, exp_ready, exp_stall);
    end
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      idle();
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected writes outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    bus.read_address0 = 3'd0;
    bus.read_address1 = 3'd0;
    #2;
    tests++;
    if ({bus.write_enable, bus.write_address, bus.write_data, bus.ready, bus.stall} !== {1'b0, 3'd0, 32'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got we=%b wa=%0d wd=%h rdy=%b st=%b required 0/0/0/1/0",
               bus.write_enable, bus.write_address, bus.write_data, bus.ready, bus.stall);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_alu();
    @(negedge clock);
    bus.read_address0 = 3'd5;
    bus.read_address1 = 3'd0;
    drive_exec(3'd5, 32'h0000_00AA, 1'b1);
    @(negedge clock);
    idle();
    chk_we("alu_after_e1", 1'b0);
    chk_ready_stall("alu_stall_e1", 1'b1, 1'b1);
    @(negedge clock);
    tests++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 3'd5 || bus.write_data !== 32'h0000_00AA) begin
      fails++;
      $display("FAIL alu_write_e2: got we=%b wa=%0d wd=%h required 1/5/000000aa",
               bus.write_enable, bus.write_address, bus.write_data);
    end
    chk_ready_stall("alu_stall_e2", 1'b1, 1'b1);
    @(negedge clock);
    chk_we("alu_after_e3", 1'b0);
    chk_ready_stall("alu_stall_e3", 1'b1, 1'b0);
    tests++;
    if (bus.write_address !== 3'd5 || bus.write_data !== 32'h0000_00AA) begin
      fails++;
      $display("FAIL alu_hold: got wa=%0d wd=%h required 5/000000aa", bus.write_address, bus.write_data);
    end
    bus.read_address0 = 3'd0;
    drain("alu", 4);
  endtask

  task automatic test_ordering();
    @(negedge clock);
    drive_load(3'd2);
    @(negedge clock);
    idle();
    drive_exec(3'd3, 32'h11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      idle();
      chk_we("order_blocked", 1'b0);
    end
    drive_mem(32'h77, 1'b1);
    @(negedge clock);
    idle();
    chk_we("order_after_fill", 1'b0);
    @(negedge clock);
    tests++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 3'd2 || bus.write_data !== 32'h77) begin
      fails++;
      $display("FAIL order_first: got we=%b wa=%0d wd=%h required 1/2/00000077",
               bus.write_enable, bus.write_address, bus.write_data);
    end
    @(negedge clock);
    tests++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 3'd3 || bus.write_data !== 32'h11) begin
      fails++;
      $display("FAIL order_second: got we=%b wa=%0d wd=%h required 1/3/00000011",
               bus.write_enable, bus.write_address, bus.write_data);
    end
    drain("order", 4);
  endtask

  task automatic test_full();
    @(negedge clock);
    chk_ready_stall("full_start", 1'b1, 1'b0);
    drive_load(3'd1);
    @(negedge clock);
    idle();
    drive_exec(3'd4, 32'h44, 1'b1);
    @(negedge clock);
    drive_exec(3'd5, 32'h55, 1'b1);
    @(negedge clock);
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL full_three: ready got %b required 1", bus.ready);
    end
    drive_exec(3'd6, 32'h66, 1'b1);
    @(negedge clock);
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL full_four: ready got %b required 0", bus.ready);
    end
    drive_exec(3'd7, 32'h99, 1'b0);
    @(negedge clock);
    idle();
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL full_after_drop: ready got %b required 0", bus.ready);
    end
    chk_we("full_no_write", 1'b0);
    drive_mem(32'h11, 1'b1);
    @(negedge clock);
    idle();
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_cycle: ready got %b required 0", bus.ready);
    end
    drive_exec(3'd7, 32'hBB, 1'b0);
    @(negedge clock);
    idle();
    tests++;
    if (bus.ready !== 1'b1 || bus.write_enable !== 1'b1 || bus.write_address !== 3'd1 || bus.write_data !== 32'h11) begin
      fails++;
      $display("FAIL full_after_pop: got rdy=%b we=%b wa=%0d wd=%h required 1/1/1/00000011",
               bus.ready, bus.write_enable, bus.write_address, bus.write_data);
    end
    drain("full", 8);
  endtask

  task automatic test_simultaneous();
    @(negedge clock);
    bus.read_address0 = 3'd3;
    bus.read_address1 = 3'd0;
    drive_exec(3'd2, 32'h22, 1'b1);
    bus.load_issue = 1'b1;
    bus.load_dest  = 3'd3;
    @(negedge clock);
    idle();
    chk_ready_stall("simul_no_load", 1'b1, 1'b0);
    @(negedge clock);
    tests++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 3'd2 || bus.write_data !== 32'h22) begin
      fails++;
      $display("FAIL simul_write: got we=%b wa=%0d wd=%h required 1/2/00000022",
               bus.write_enable, bus.write_address, bus.write_data);
    end
    drive_mem(32'h33, 1'b0);
    @(negedge clock);
    idle();
    chk_we("simul_dropped_load", 1'b0);
    bus.read_address0 = 3'd0;
    drain("simul", 3);
    // push, fill and pop in the same cycle
    @(negedge clock);
    drive_load(3'd5);
    @(negedge clock);
    idle();
    drive_exec(3'd4, 32'h40, 1'b1);
    @(negedge clock);
    idle();
    drive_load(3'd6);
    @(negedge clock);
    idle();
    drive_mem(32'h50, 1'b1);
    @(negedge clock);
    idle();
    chk_we("pfp_before", 1'b0);
    drive_mem(32'h60, 1'b1);
    drive_exec(3'd7, 32'h70, 1'b1);
    @(negedge clock);
    idle();
    tests++;
    if (bus.ready !== 1'b1 || bus.write_enable !== 1'b1 || bus.write_address !== 3'd5 || bus.write_data !== 32'h50) begin
      fails++;
      $display("FAIL pfp_cycle: got rdy=%b we=%b wa=%0d wd=%h required 1/1/5/00000050",
               bus.ready, bus.write_enable, bus.write_address, bus.write_data);
    end
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    tests++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 3'd7 || bus.write_data !== 32'h70) begin
      fails++;
      $display("FAIL pfp_last: got we=%b wa=%0d wd=%h required 1/7/00000070",
               bus.write_enable, bus.write_address, bus.write_data);
    end
    @(negedge clock);
    chk_we("pfp_empty", 1'b0);
    chk_ready_stall("pfp_ready", 1'b1, 1'b0);
    drain("pfp", 3);
  endtask

  task automatic test_spurious();
    @(negedge clock);
    drive_mem(32'hDEAD, 1'b0);
    @(negedge clock);
    idle();
    chk_we("spur_e1", 1'b0);
    chk_ready_stall("spur_ready", 1'b1, 1'b0);
    drive_load(3'd1);
    @(negedge clock);
    idle();
    chk_we("spur_e2", 1'b0);
    @(negedge clock);
    chk_we("spur_e3", 1'b0);
    drive_mem(32'hCAFE, 1'b1);
    @(negedge clock);
    idle();
    @(negedge clock);
    tests++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 3'd1 || bus.write_data !== 32'hCAFE) begin
      fails++;
      $display("FAIL spur_load_data: got we=%b wa=%0d wd=%h required 1/1/0000cafe",
               bus.write_enable, bus.write_address, bus.write_data);
    end
    drain("spur", 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bus.read_address0 = 3'd2;
    drive_load(3'd1);
    @(negedge clock);
    idle();
    drive_load(3'd2);
    @(negedge clock);
    idle();
    drive_load(3'd3);
    @(negedge clock);
    idle();
    chk_ready_stall("rmid_before", 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({bus.write_enable, bus.write_address, bus.write_data, bus.ready, bus.stall} !== {1'b0, 3'd0, 32'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL rmid_reset: got we=%b wa=%0d wd=%h rdy=%b st=%b required 0/0/0/1/0",
               bus.write_enable, bus.write_address, bus.write_data, bus.ready, bus.stall);
    end
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    drive_mem(32'h5A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle();
      chk_we("rmid_no_write", 1'b0);
      chk_ready_stall("rmid_idle", 1'b1, 1'b0);
    end
    drive_exec(3'd3, 32'h3, 1'b1);
    bus.read_address0 = 3'd0;
    drain("rmid", 4);
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_ordering();
    test_full();
    test_simultaneous();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/write_back_unit.md
# write_back_unit

In-order write-back stage for the Risky pipeline: the producing end of the register-file write port whose read side is used by the read stage. Accepts ALU results and load issues from execute in program order and completes memory load data out of a small in-order completion queue. Retires entries to the register file one per cycle and raises `stall` to the read stage while a source register has an unretired write.

## Interface
- `DATA_WIDTH`, 32, register/data width
- `GPR_WIDTH`, 3, register index width (8 GPRs)
- `DEPTH`, 4, completion-queue entries (power of two, ≥2)
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `exec_valid`  in  1  ALU result push
- `exec_dest`  in  GPR_WIDTH  destination of ALU result
- `exec_result`  in  DATA_WIDTH  ALU result data
- `load_issue`  in  1  load issued; allocate entry with data pending
- `load_dest`  in  GPR_WIDTH  load destination
- `mem_valid`  in  1  load data return, strictly in issue order
- `mem_data`  in  DATA_WIDTH  load data
- `read_address0`, `read_address1`  in  GPR_WIDTH  current read-stage sources
- `ready`  out  1  queue can accept a push this cycle
- `stall`  out  1  combinational hazard to read stage
- `write_enable`  out  1  register-file write strobe (registered)
- `write_address`  out  GPR_WIDTH  write index (registered)
- `write_data`  out  DATA_WIDTH  write data (registered)

## Operation
- Queue: circular buffer, head/tail pointers, `count` 0..DEPTH; entry = {valid, dest, data, data_valid}.
- `ready` = (`count` < DEPTH), from registered count only; a pop in the same cycle does not free space.
- Push: `exec_valid` allocates at tail with data_valid=1; `load_issue` allocates with data_valid=0. Both high: exec wins, load_issue dropped. Push while `ready`=0: dropped, no state change.
- Fill: `mem_valid` writes `mem_data` into the oldest entry with data_valid=0, marks it valid. Entries allocated in the same cycle are not eligible. `mem_valid` with no pending load: ignored.
- Retire: if head valid and data_valid, pop it and register {1, dest, data} onto write outputs; otherwise `write_enable`←0, address/data hold.
- Push, fill, pop may all happen in one cycle; `count` = count + push − pop.
- `stall` = any valid queue entry's dest matches `read_address0` or `read_address1`, or `write_enable`=1 and `write_address` matches either. All registers treated alike (r0 included). Read stage sends read_address 0 for unused sources, so spurious stalls on r0 are accepted.

## Timing
- Reset (async assert): queue empty, pointers/count 0, `write_enable`=0, `write_address`=0, `write_data`=0; hence `ready`=1, `stall`=0. Reset mid-operation discards all pending entries and outstanding loads.
- ALU result pushed at edge N → `write_enable` high in cycle after edge N+1 if queue was otherwise empty; register file captures at edge N+2.
- Load issued at edge N, `mem_valid` sampled at edge M>N → `write_enable` high after edge M+1 if it is head.
- Throughput: one retire per cycle; a pending load at head blocks younger completed entries (strict program order).
- `stall` asserted in the cycle after the matching push edge, deasserts the cycle after the write-output cycle.

## Test plan
- Reset: assert `reset`=0 mid-traffic with count=3 → all outputs 0, `ready`=1, `stall`=0 immediately; later `mem_valid` ignored.
- Single ALU write: exec_dest=5, result=0x0000_00AA at edge 1 → write_enable=1, address=5, data=0xAA after edge 2 only; read_address0=5 gives stall=1 in cycles after edges 1 and 2, 0 after edge 3.
- Ordering: load r2 at edge 1, ALU r3=0x11 at edge 2, mem_valid data=0x77 at edge 5 → writes r2=0x77 after edge 6 then r3=0x11 after edge 7; no r3 write earlier.
- Full: four pushes without mem return (head a load) → ready=0; fifth exec push dropped; after fill and one pop, ready=1 only the cycle after the pop.
- Simultaneous: exec_valid and load_issue same cycle → only ALU entry allocated, count +1; push+fill+pop in one cycle keeps count consistent.
- Spurious memory: mem_valid=1 with empty queue → no write, count unchanged.
